// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage and the IF/ID buffer downstream of it.
package if_pkg;

  localparam int          IF_ADDR_W   = 32;
  localparam int          IF_INSTR_W  = 32;
  localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_IDLE  = 2'd0;
  localparam fetch_state_t ST_REQ   = 2'd1;
  localparam fetch_state_t ST_SKID  = 2'd2;
  localparam fetch_state_t ST_DRAIN = 2'd3;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {pc4, instr} holding slot for a fetch response that arrives while IF/ID is stalled.
module fetch_skid_buffer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              unload_i,
  input  logic              clear_i,
  input  logic [ADDR_W-1:0] pc4_i,
  input  logic [DATA_W-1:0] instr_i,
  output logic              full_o,
  output logic [ADDR_W-1:0] pc4_o,
  output logic [DATA_W-1:0] instr_o
);

  logic              full_q, full_d;
  logic [ADDR_W-1:0] pc4_q, pc4_d;
  logic [DATA_W-1:0] instr_q, instr_d;

  // Clear (flush) wins over a simultaneous load.
  always_comb begin
    full_d  = full_q;
    pc4_d   = pc4_q;
    instr_d = instr_q;
    if (clear_i) begin
      full_d  = 1'b0;
      pc4_d   = '0;
      instr_d = '0;
    end else if (load_i) begin
      full_d  = 1'b1;
      pc4_d   = pc4_i;
      instr_d = instr_i;
    end else if (unload_i) begin
      full_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q  <= 1'b0;
      pc4_q   <= '0;
      instr_q <= '0;
    end else begin
      full_q  <= full_d;
      pc4_q   <= pc4_d;
      instr_q <= instr_d;
    end
  end

  assign full_o  = full_q;
  assign pc4_o   = pc4_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, fetches over a variable-latency req/ack port and feeds the IF/ID buffer.
module instruction_fetch_unit
  import if_pkg::*;
#(
  parameter int                ADDR_W   = IF_ADDR_W,
  parameter int                DATA_W   = IF_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IF_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] if_pc4,
  output logic [DATA_W-1:0] if_instr,
  output logic              if_valid
);

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic [ADDR_W-1:0] if_pc4_q, if_pc4_d;
  logic [DATA_W-1:0] if_instr_q, if_instr_d;
  logic              if_valid_q, if_valid_d;

  logic              skid_load, skid_unload, skid_clear, skid_full;
  logic [ADDR_W-1:0] skid_pc4;
  logic [DATA_W-1:0] skid_instr;
  logic [ADDR_W-1:0] pc_plus4, redir_target;
  logic              slot_free;

  assign pc_plus4     = pc_q + PC_STEP;
  assign redir_target = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign slot_free    = !if_valid_q || !stall;

  fetch_skid_buffer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .clear_i  (skid_clear),
    .pc4_i    (pc_plus4),
    .instr_i  (imem_rdata),
    .full_o   (skid_full),
    .pc4_o    (skid_pc4),
    .instr_o  (skid_instr)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_pc_d   = pend_pc_q;
    if_pc4_d    = if_pc4_q;
    if_instr_d  = if_instr_q;
    if_valid_d  = if_valid_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_clear  = 1'b0;

    if (redirect) begin
      if_valid_d = 1'b0;
      skid_clear = 1'b1;
      // An unanswered request must keep its address until acked, so the target waits in pend_pc.
      if ((state_q == ST_REQ || state_q == ST_DRAIN) && !imem_ack) begin
        state_d   = ST_DRAIN;
        pend_pc_d = redir_target;
      end else begin
        state_d = ST_REQ;
        pc_d    = redir_target;
      end
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_REQ;
        ST_REQ: begin
          if (imem_ack) begin
            pc_d = pc_plus4;
            if (slot_free) begin
              if_valid_d = 1'b1;
              if_pc4_d   = pc_plus4;
              if_instr_d = imem_rdata;
            end else begin
              skid_load = 1'b1;
              state_d   = ST_SKID;
            end
          end else if (!stall) begin
            if_valid_d = 1'b0;
          end
        end
        ST_SKID: begin
          if (!stall && skid_full) begin
            if_valid_d  = 1'b1;
            if_pc4_d    = skid_pc4;
            if_instr_d  = skid_instr;
            skid_unload = 1'b1;
            state_d     = ST_REQ;
          end
        end
        ST_DRAIN: begin
          if (imem_ack) begin
            pc_d    = pend_pc_q;
            state_d = ST_REQ;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      pend_pc_q  <= '0;
      if_pc4_q   <= '0;
      if_instr_q <= '0;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_pc_q  <= pend_pc_d;
      if_pc4_q   <= if_pc4_d;
      if_instr_q <= if_instr_d;
      if_valid_q <= if_valid_d;
    end
  end

  assign imem_req  = (state_q == ST_REQ) || (state_q == ST_DRAIN);
  assign imem_addr = pc_q;
  assign if_pc4    = if_pc4_q;
  assign if_instr  = if_instr_q;
  assign if_valid  = if_valid_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: latency-programmable memory model, scoreboard and redirect table.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] if_pc4;
  logic [31:0] if_instr;
  logic        if_valid;

  instruction_fetch_unit #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_pc4      (if_pc4),
    .if_instr    (if_instr),
    .if_valid    (if_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc4;
    logic [31:0] instr;
  } fetch_t;

  typedef struct {
    logic [31:0] rpc;
    int          lat;
    bit          twice;
    logic [31:0] first_rpc;
    logic [31:0] exp_pc4;
    logic [31:0] exp_instr;
  } redir_vec_t;

  int     n_vec  = 0;
  int     n_fail = 0;
  int     n_pops = 0;
  int     lat    = 1;
  int     cnt;
  fetch_t sb[$];

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'h1000_0000 + {2'b00, a[31:2]};
  endfunction

  // Memory answers in the lat-th cycle of a held request (lat=1 acks combinationally).
  assign imem_ack   = imem_req && (cnt >= lat - 1);
  assign imem_rdata = word(imem_addr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    cnt <= 0;
    else if (imem_req && !imem_ack) cnt <= cnt + 1;
    else                           cnt <= 0;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: predicts every fetch from the bench's own stimulus and checks consumption.
  initial begin
    logic [31:0] exp_addr;
    logic [31:0] hold_addr;
    bit          stale;
    bit          hold;
    fetch_t      e;
    exp_addr = RESET_PC;
    stale    = 0;
    hold     = 0;
    hold_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        exp_addr = RESET_PC;
        stale    = 0;
        hold     = 0;
      end else begin
        if (hold) chk("req_hold", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, hold_addr});
        if (if_valid && !stall && !redirect) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL sb_empty: got pc4 %h instr %h, nothing expected", if_pc4, if_instr);
          end else begin
            e = sb.pop_front();
            chk("sb_out", {if_pc4, if_instr}, {e.pc4, e.instr});
            n_pops++;
          end
        end
        if (redirect) begin
          sb.delete();
          exp_addr = {redirect_pc[31:2], 2'b00};
          stale    = imem_req && !imem_ack;
        end else if (imem_req && imem_ack) begin
          if (stale) begin
            stale = 0;
          end else begin
            chk("fetch_addr", {32'd0, imem_addr}, {32'd0, exp_addr});
            e.pc4   = imem_addr + 32'd4;
            e.instr = word(imem_addr);
            sb.push_back(e);
            exp_addr = exp_addr + 32'd4;
          end
        end
        hold      = imem_req && !imem_ack;
        hold_addr = imem_addr;
      end
    end
  end

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"}, {63'd0, if_valid}, 64'd0);
    chk({tag, "_pc4"}, {32'd0, if_pc4}, 64'd0);
    chk({tag, "_instr"}, {32'd0, if_instr}, 64'd0);
    chk({tag, "_req"}, {63'd0, imem_req}, 64'd0);
    chk({tag, "_addr"}, {32'd0, imem_addr}, {32'd0, RESET_PC});
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n;
    n = 0;
    while (!if_valid && n < budget) begin
      tick();
      n++;
    end
    if (!if_valid) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s: if_valid never rose within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_outstanding(input int budget);
    int n;
    n = 0;
    while (!(imem_req && !imem_ack) && n < budget) begin
      tick();
      n++;
    end
    if (!(imem_req && !imem_ack)) begin
      n_vec++;
      n_fail++;
      $display("FAIL outstanding: no held request within %0d cycles", budget);
    end
  endtask

  task automatic stall_seq(input int n);
    logic [31:0] fpc4, finstr;
    chk("stall_pre_valid", {63'd0, if_valid}, 64'd1);
    fpc4   = if_pc4;
    finstr = if_instr;
    stall  = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      chk("stall_frozen", {if_pc4, if_instr}, {fpc4, finstr});
      chk("stall_valid", {63'd0, if_valid}, 64'd1);
    end
    chk("skid_no_req", {63'd0, imem_req}, 64'd0);
    stall = 1'b0;
    tick();
    chk("stall_next_pc4", {32'd0, if_pc4}, {32'd0, fpc4 + 32'd4});
    chk("stall_next_instr", {32'd0, if_instr}, {32'd0, word(fpc4)});
  endtask

  initial begin
    redir_vec_t vt[6];
    int         p0;
    bit         prev_v;

    vt[0] = '{32'h0000_0103, 1, 1'b0, 32'h0, 32'h0000_0104, 32'h1000_0040};
    vt[1] = '{32'h0000_0103, 3, 1'b0, 32'h0, 32'h0000_0104, 32'h1000_0040};
    vt[2] = '{32'hFFFF_FFFC, 1, 1'b0, 32'h0, 32'h0000_0000, 32'h4FFF_FFFF};
    vt[3] = '{32'h0000_0202, 2, 1'b0, 32'h0, 32'h0000_0204, 32'h1000_0080};
    vt[4] = '{32'h8000_0001, 4, 1'b0, 32'h0, 32'h8000_0004, 32'h3000_0000};
    vt[5] = '{32'h0000_0703, 4, 1'b1, 32'h0000_0500, 32'h0000_0704, 32'h1000_01C0};

    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    lat         = 1;
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset");

    // Zero-wait streaming from RESET_PC.
    rst_n = 1'b1;
    tick();
    chk("idle_to_req", {63'd0, imem_req}, 64'd1);
    chk("first_not_valid", {63'd0, if_valid}, 64'd0);
    tick();
    for (int k = 1; k <= 6; k++) begin
      chk("stream_valid", {63'd0, if_valid}, 64'd1);
      chk("stream_pc4", {32'd0, if_pc4}, {32'd0, 32'(4 * k)});
      chk("stream_instr", {32'd0, if_instr}, {32'd0, 32'h1000_0000 + 32'(k - 1)});
      tick();
    end

    // Three-cycle latency: one single-cycle valid pulse per fetch.
    lat = 3;
    repeat (6) tick();
    p0     = n_pops;
    prev_v = if_valid;
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("lat3_pulse", {63'd0, if_valid && prev_v}, 64'd0);
      prev_v = if_valid;
    end
    chk("lat3_rate", 64'(n_pops - p0), 64'd10);

    // Stall while valid with a response landing in the skid slot.
    lat = 1;
    repeat (3) tick();
    stall_seq(4);
    lat = 3;
    wait_valid("stall3_valid", 20);
    stall_seq(5);

    // Redirect table.
    for (int v = 0; v < 6; v++) begin
      lat = vt[v].lat;
      repeat (4) tick();
      if (vt[v].lat > 1) wait_outstanding(20);
      redirect    = 1'b1;
      redirect_pc = vt[v].twice ? vt[v].first_rpc : vt[v].rpc;
      tick();
      if (vt[v].twice) begin
        redirect_pc = vt[v].rpc;
        tick();
      end
      redirect = 1'b0;
      chk("redir_flush", {63'd0, if_valid}, 64'd0);
      wait_valid("redir_valid", 30);
      chk("redir_pc4", {32'd0, if_pc4}, {32'd0, vt[v].exp_pc4});
      chk("redir_instr", {32'd0, if_instr}, {32'd0, vt[v].exp_instr});
      if (vt[v].lat == 1) chk("redir_next_addr", {32'd0, imem_addr}, {32'd0, vt[v].exp_pc4});
    end

    // Reset pulsed while a request is waiting for its ack.
    lat = 3;
    repeat (4) tick();
    wait_outstanding(20);
    #2 rst_n = 1'b0;
    #1 chk_zero_outputs("rst_wait");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_wait_req", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, RESET_PC});
    repeat (10) tick();

    // Reset pulsed while a word sits in the skid slot.
    lat = 1;
    repeat (3) tick();
    stall = 1'b1;
    tick();
    tick();
    chk("skid_req_low", {63'd0, imem_req}, 64'd0);
    #2 rst_n = 1'b0;
    #1 chk_zero_outputs("rst_skid");
    stall = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_skid_req", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, RESET_PC});
    tick();
    chk("rst_skid_pc4", {32'd0, if_pc4}, {32'd0, RESET_PC + 32'd4});
    repeat (6) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
